// File: rtl/prog_loader.sv
// prog_loader: program-load initiator for the core instruction cache.
// It accepts a 32-bit word stream over a valid/ready handshake and writes the
// words to consecutive i-cache addresses starting at 0. After a programmable
// idle delay it raises start and holds it, so the core runs from pc=0.
//
// Optional feature macro: PROG_LOADER_PAD_NOP_EN
//   defined   : every address past the program is filled with NOP_WORD
//               before start rises.
//   undefined : LOAD goes straight to WAIT, and addresses past the program
//               keep their old contents.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   load_req        1-cycle pulse that begins a new load (from IDLE or RUN)
//   s_valid/s_ready stream handshake; a transfer is valid & ready
//   s_data, s_last  stream word and end-of-program marker
//   i_instruction   i-cache write data
//   i_addr, i_wea   i-cache write address and write-enable pulse
//   start           core run enable (level)
//   busy            high during LOAD/PAD/WAIT
//   word_count      stream words written in the last or current load
//   err_overflow    sticky: the stream exceeded DEPTH words
module prog_loader #(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned START_DELAY = 2
`ifdef PROG_LOADER_PAD_NOP_EN
   ,
   parameter logic [31:0] NOP_WORD    = 32'h0000_0013
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_req,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [31:0]       s_data,
   input  logic              s_last,
   output logic [31:0]       i_instruction,
   output logic [ADDR_W-1:0] i_addr,
   output logic              i_wea,
   output logic              start,
   output logic              busy,
   output logic [ADDR_W:0]   word_count,
   output logic              err_overflow
);

   localparam int unsigned WP_W  = ADDR_W + 1;
   localparam int unsigned DLY_W = 4;
   localparam logic [WP_W-1:0]  LAST_WP = WP_W'(DEPTH - 1);
   localparam logic [WP_W-1:0]  FULL_WP = WP_W'(DEPTH);
   localparam logic [DLY_W-1:0] DLY_END = DLY_W'(START_DELAY);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_PAD,
      S_WAIT,
      S_RUN
   } state_t;

   state_t            state, state_n;
   logic [WP_W-1:0]   wp, wp_n;
   logic [DLY_W-1:0]  dly, dly_n;
   logic [WP_W-1:0]   wc_n;
   logic              err_n;
   logic              wea_n;
   logic [ADDR_W-1:0] addr_n;
   logic [31:0]       instr_n;
   logic              xfer;

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         wp            <= '0;
         dly           <= '0;
         word_count    <= '0;
         err_overflow  <= 1'b0;
         i_wea         <= 1'b0;
         i_addr        <= '0;
         i_instruction <= '0;
         s_ready       <= 1'b0;
         start         <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state         <= state_n;
         wp            <= wp_n;
         dly           <= dly_n;
         word_count    <= wc_n;
         err_overflow  <= err_n;
         i_wea         <= wea_n;
         i_addr        <= addr_n;
         i_instruction <= instr_n;
         s_ready       <= (state_n == S_LOAD);
         start         <= (state_n == S_RUN);
         busy          <= (state_n == S_LOAD) || (state_n == S_PAD) || (state_n == S_WAIT);
      end
   end

   // Next state and next register values
   always_comb begin
      state_n = state;
      wp_n    = wp;
      dly_n   = dly;
      wc_n    = word_count;
      err_n   = err_overflow;
      wea_n   = 1'b0;
      addr_n  = i_addr;
      instr_n = i_instruction;
      xfer    = s_valid && s_ready;

      case (state)
         S_IDLE, S_RUN: begin
            if (load_req) begin
               state_n = S_LOAD;
               wp_n    = '0;
               wc_n    = '0;
               err_n   = 1'b0;
            end
         end
         S_LOAD: begin
            if (xfer) begin
               wea_n   = 1'b1;
               addr_n  = wp[ADDR_W-1:0];
               instr_n = s_data;
               wp_n    = wp + 1'b1;
               if (word_count != FULL_WP) begin
                  wc_n = word_count + 1'b1;
               end
               // The final address ends the load even without s_last
               if (s_last || (wp == LAST_WP)) begin
                  if (!s_last) begin
                     err_n = 1'b1;
                  end
                  dly_n = '0;
`ifdef PROG_LOADER_PAD_NOP_EN
                  state_n = (wp == LAST_WP) ? S_WAIT : S_PAD;
`else
                  state_n = S_WAIT;
`endif
               end
            end
         end
`ifdef PROG_LOADER_PAD_NOP_EN
         S_PAD: begin
            wea_n   = 1'b1;
            addr_n  = wp[ADDR_W-1:0];
            instr_n = NOP_WORD;
            wp_n    = wp + 1'b1;
            if (wp == LAST_WP) begin
               dly_n   = '0;
               state_n = S_WAIT;
            end
         end
`endif
         S_WAIT: begin
            // First WAIT cycle carries the trailing write; count idle cycles after it
            if (dly == DLY_END) begin
               state_n = S_RUN;
            end else begin
               dly_n = dly + 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

endmodule
